// File: rtl/note_sequence_recorder.sv
// Records note events (note code + duration in beats) into an on-chip buffer and replays them paced by the beat tick.
// Optional build macro RECORDER_LOOP_EN: replay restarts from entry 0 at end of sequence instead of returning to IDLE.
module note_sequence_recorder #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              playback,
  input  logic              beat,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  dur_in,
  input  logic              note_in_valid,
  output logic [NOTE_W-1:0] note_out,
  output logic [DUR_W-1:0]  dur_out,
  output logic              note_out_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned ENTRY_W = NOTE_W + DUR_W;
  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DUR_W-1:0]  BEAT_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

  // Valid/ready: there is no back-pressure; note_in_valid and note_out_valid are
  // single-cycle qualifiers that are consumed/presented in the cycle they are high.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_FETCH  = 2'd2,
    S_PLAY   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [NOTE_W-1:0]   note_out_q, note_out_d;
  logic [DUR_W-1:0]    dur_out_q, dur_out_d;
  logic                valid_q, valid_d;
  logic [DUR_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                first_q, first_d;
  logic                wr_en;
  logic [ADDR_W:0]     rd_next;

  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= {note_in, dur_in};
    end
    rd_data_q <= mem_q[rd_ptr_q];
  end

  assign rd_next = {1'b0, rd_ptr_q} + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    note_out_d = note_out_q;
    dur_out_d  = dur_out_q;
    valid_d    = 1'b0;
    beat_cnt_d = beat_cnt_q;
    first_d    = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (record) begin
          state_d    = S_RECORD;
          wr_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (playback && (count_q != '0)) begin
          state_d  = S_FETCH;
          rd_ptr_d = '0;
        end
      end
      S_RECORD: begin
        if (note_in_valid) begin
          if (count_q < DEPTH_C) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (record) begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (playback) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PLAY;
          first_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (playback) begin
          state_d = S_IDLE;
        end else if (first_q) begin
          // RAM data for rd_ptr is available now; present it for exactly one cycle.
          note_out_d = rd_data_q[ENTRY_W-1:DUR_W];
          dur_out_d  = rd_data_q[DUR_W-1:0];
          beat_cnt_d = rd_data_q[DUR_W-1:0];
          valid_d    = 1'b1;
        end else if (beat_cnt_q == '0) begin
          if (rd_next < count_q) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            state_d  = S_FETCH;
          end else begin
`ifdef RECORDER_LOOP_EN
            rd_ptr_d = '0;
            state_d  = S_FETCH;
`else
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            state_d  = S_IDLE;
`endif
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q - BEAT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      note_out_q <= '0;
      dur_out_q  <= '0;
      valid_q    <= 1'b0;
      beat_cnt_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      note_out_q <= note_out_d;
      dur_out_q  <= dur_out_d;
      valid_q    <= valid_d;
      beat_cnt_q <= beat_cnt_d;
      first_q    <= first_d;
    end
  end

  assign note_out       = note_out_q;
  assign dur_out        = dur_out_q;
  assign note_out_valid = valid_q;
  assign state          = state_q;
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_note_sequence_recorder.sv
// Self-checking bench for note_sequence_recorder: records note sequences and checks replay
// content and beat pacing against a queue model of the stored entries.
module tb_note_sequence_recorder;

`ifdef RECORDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       record = 1'b0;
  logic       playback = 1'b0;
  logic       beat = 1'b0;
  logic [5:0] note_in = '0;
  logic [5:0] dur_in = '0;
  logic       note_in_valid = 1'b0;
  logic [5:0] note_out;
  logic [5:0] dur_out;
  logic       note_out_valid;
  logic [1:0] state;
  logic [6:0] count;
  logic       overflow;

  int tests_run = 0;
  int tests_failed = 0;

  logic [11:0] exp_q[$];
  logic        ovf_exp;

  note_sequence_recorder dut (
    .clk(clk), .reset(reset), .record(record), .playback(playback), .beat(beat),
    .note_in(note_in), .dur_in(dur_in), .note_in_valid(note_in_valid),
    .note_out(note_out), .dur_out(dur_out), .note_out_valid(note_out_valid),
    .state(state), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_record();
    exp_q.delete();
    ovf_exp = 1'b0;
    record = 1'b1;
    tick();
    record = 1'b0;
  endtask

  // Model: buffer keeps only the first 64 accepted entries; later attempts set overflow.
  task automatic write_note(input logic [5:0] n, input logic [5:0] d, input logic stop);
    note_in = n; dur_in = d; note_in_valid = 1'b1; record = stop;
    tick();
    note_in_valid = 1'b0; record = 1'b0;
    if (exp_q.size() < 64) exp_q.push_back({n, d});
    else ovf_exp = 1'b1;
  endtask

  task automatic check_stored(input string name);
    tests_run++;
    if (count !== 7'(exp_q.size()) || overflow !== ovf_exp || state !== 2'd0) begin
      tests_failed++;
      $display("FAIL %s stored: count=%0d ovf=%0b state=%0d expected count=%0d ovf=%0b state=0",
               name, count, overflow, state, exp_q.size(), ovf_exp);
    end
  endtask

  // Replays and expects entries exp_q[i % size] in order. end_mode 0: natural end to IDLE;
  // end_mode 1: stop with a playback pulse after n_pulses notes.
  task automatic replay_check(input string name, input int n_pulses, input int end_mode);
    logic [11:0] e;
    int d;
    playback = 1'b1;
    tick();
    playback = 1'b0;
    tests_run++;
    if (state !== 2'd2 || note_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s start: state=%0d valid=%0b expected state=2 valid=0", name, state, note_out_valid);
    end
    for (int i = 0; i < n_pulses; i++) begin
      for (int w = 0; w < ((i == 0) ? 1 : 2); w++) begin
        tick();
        tests_run++;
        if (note_out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s early pulse before note %0d: valid=%0b expected 0", name, i, note_out_valid);
        end
      end
      tick();
      e = exp_q[i % exp_q.size()];
      tests_run++;
      if (note_out_valid !== 1'b1 || {note_out, dur_out} !== e) begin
        tests_failed++;
        $display("FAIL %s note %0d: valid=%0b note=%0d dur=%0d expected valid=1 note=%0d dur=%0d",
                 name, i, note_out_valid, note_out, dur_out, e[11:6], e[5:0]);
      end
      if (i == n_pulses - 1 && end_mode == 1) break;
      d = int'(e[5:0]);
      for (int b = 0; b < d; b++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          tick();
          tests_run++;
          if (note_out_valid !== 1'b0 || state !== 2'd3) begin
            tests_failed++;
            $display("FAIL %s hold note %0d: valid=%0b state=%0d expected valid=0 state=3",
                     name, i, note_out_valid, state);
          end
        end
        beat = 1'b1;
        tick();
        beat = 1'b0;
      end
      if (i == n_pulses - 1) begin
        tests_run++;
        if (state !== 2'd3) begin
          tests_failed++;
          $display("FAIL %s last note hold: state=%0d expected 3", name, state);
        end
        tick();
        tests_run++;
        if (state !== 2'd0) begin
          tests_failed++;
          $display("FAIL %s end of sequence: state=%0d expected 0", name, state);
        end
      end
    end
    if (end_mode == 1) begin
      tick();
      playback = 1'b1;
      tick();
      playback = 1'b0;
      tests_run++;
      if (state !== 2'd0) begin
        tests_failed++;
        $display("FAIL %s stop: state=%0d expected 0", name, state);
      end
    end
    for (int t = 0; t < 10; t++) begin
      beat = 1'($urandom_range(0, 1));
      tick();
      beat = 1'b0;
      tests_run++;
      if (note_out_valid !== 1'b0 || state !== 2'd0) begin
        tests_failed++;
        $display("FAIL %s after end: valid=%0b state=%0d expected valid=0 state=0",
                 name, note_out_valid, state);
      end
    end
    tests_run++;
    if (count !== 7'(exp_q.size())) begin
      tests_failed++;
      $display("FAIL %s count retained: got %0d expected %0d", name, count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests_run++;
    if (state !== 2'd0 || count !== 7'd0 || overflow !== 1'b0 || note_out !== 6'd0 ||
        dur_out !== 6'd0 || note_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: state=%0d count=%0d ovf=%0b note=%0d dur=%0d valid=%0b expected all 0",
               state, count, overflow, note_out, dur_out, note_out_valid);
    end
  endtask

  task automatic test_basic();
    start_record();
    write_note(6'd5, 6'd2, 1'b0);
    write_note(6'd9, 6'd1, 1'b0);
    write_note(6'd12, 6'd0, 1'b1);
    check_stored("basic");
    replay_check("basic", LOOP ? 4 : 3, LOOP ? 1 : 0);
  endtask

  task automatic test_reset_mid_record();
    start_record();
    for (int i = 0; i < 3; i++) write_note(6'($urandom_range(1, 63)), 6'($urandom_range(0, 63)), 1'b0);
    tests_run++;
    if (count !== 7'd3 || state !== 2'd1) begin
      tests_failed++;
      $display("FAIL mid_record: count=%0d state=%0d expected count=3 state=1", count, state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    tests_run++;
    if (count !== 7'd0 || state !== 2'd0 || note_out !== 6'd0 || dur_out !== 6'd0 ||
        note_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_record: count=%0d state=%0d note=%0d dur=%0d valid=%0b expected all 0",
               count, state, note_out, dur_out, note_out_valid);
    end
  endtask

  task automatic test_empty_and_priority();
    playback = 1'b1;
    tick();
    playback = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tests_run++;
      if (state !== 2'd0 || note_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL empty_playback: state=%0d valid=%0b expected state=0 valid=0", state, note_out_valid);
      end
      tick();
    end
    record = 1'b1; playback = 1'b1;
    tick();
    record = 1'b0; playback = 1'b0;
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL record_priority: state=%0d expected 1", state);
    end
    playback = 1'b1;
    tick();
    playback = 1'b0;
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL playback_in_record: state=%0d expected 1", state);
    end
    exp_q.delete();
    ovf_exp = 1'b0;
    write_note(6'd33, 6'd1, 1'b1);
    check_stored("priority");
  endtask

  task automatic test_overflow();
    start_record();
    for (int i = 0; i < 65; i++)
      write_note(6'($urandom_range(0, 63)), 6'($urandom_range(0, 2)), (i == 64));
    check_stored("overflow");
    replay_check("overflow", LOOP ? 65 : 64, LOOP ? 1 : 0);
  endtask

  task automatic test_stop_mid_play();
    start_record();
    for (int i = 0; i < 4; i++)
      write_note(6'($urandom_range(0, 63)), 6'($urandom_range(2, 5)), (i == 3));
    check_stored("stop");
    replay_check("stop", 2, 1);
  endtask

  task automatic test_loop();
    start_record();
    write_note(6'd17, 6'd1, 1'b0);
    write_note(6'd42, 6'd0, 1'b1);
    check_stored("loop");
    replay_check("loop", LOOP ? 5 : 2, LOOP ? 1 : 0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      start_record();
      for (int i = 0; i < n; i++)
        write_note(6'($urandom_range(0, 63)), 6'($urandom_range(0, 3)), (i == n - 1));
      check_stored("random");
      replay_check("random", LOOP ? n + 1 : n, LOOP ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_record();
    test_empty_and_priority();
    test_overflow();
    test_stop_mid_play();
    test_loop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
